// File: rtl/vga_text_pkg.sv
// vga_text_pkg: text geometry, control codes, clear fill word, writer FSM states and VRAM word-address helper
package vga_text_pkg;
  localparam int TEXT_COLS = 80;
  localparam int TEXT_ROWS = 30;
  localparam int VRAM_WORDS = 600;
  localparam int CTRL_ADDR = 600;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [31:0] CLEAR_FILL = 32'h2020_2020;
  typedef enum logic [1:0] {IDLE, CHAR_WR, CLEAR_RUN, CTRL_WR} state_t;
  function automatic logic [11:0] vram_addr(input logic [4:0] row, input logic [6:0] col);
    return 12'(row) * 12'd20 + 12'(col[6:2]);
  endfunction
endpackage

// File: rtl/vga_text_cursor.sv
// vga_text_cursor: col/row cursor (clk, rst, advance, newline, cr, home -> col 0..79, row 0..29), wraps to row 0 without scrolling
module vga_text_cursor
  import vga_text_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic       newline,
  input  logic       cr,
  input  logic       home,
  output logic [6:0] col,
  output logic [4:0] row
);
  logic       last_col;
  logic       row_inc;
  logic [6:0] col_n;
  logic [4:0] row_n;
  assign last_col = col == 7'(TEXT_COLS - 1);
  assign row_inc = newline || (advance && last_col);
  always_comb begin
    col_n = (home || newline || cr || (advance && last_col)) ? 7'd0 : advance ? col + 7'd1 : col;
    row_n = home ? 5'd0 : !row_inc ? row : (row == 5'(TEXT_ROWS - 1)) ? 5'd0 : row + 5'd1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= col_n;
      row <= row_n;
    end
  end
endmodule

// File: rtl/vga_text_avl_writer.sv
// vga_text_avl_writer: Avalon-MM master turning glyph bytes (CHAR_*), CLEAR and CTRL_* requests into VRAM/ctrl writes (AVL_M_*), with BUSY and CURSOR_*; VGA_TEXT_WRITER_CTRL_EN enables the control-register path
module vga_text_avl_writer
  import vga_text_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CHAR_VALID,
  input  logic [7:0]  CHAR_DATA,
  output logic        CHAR_READY,
  input  logic        CLEAR,
  input  logic        CTRL_WRITE,
  input  logic [31:0] CTRL_DATA,
  output logic [11:0] AVL_M_ADDR,
  output logic        AVL_M_WRITE,
  output logic [3:0]  AVL_M_BYTE_EN,
  output logic [31:0] AVL_M_WRITEDATA,
  input  logic        AVL_M_WAITREQUEST,
  output logic        BUSY,
  output logic [6:0]  CURSOR_COL,
  output logic [4:0]  CURSOR_ROW
);
  state_t      state, state_n;
  logic        init;
  logic        clear_pend, clear_pend_n;
  logic [11:0] addr_n;
  logic        write_n;
  logic [3:0]  be_n;
  logic [31:0] data_n;
  logic        done, accept, is_lf, is_cr;
  logic        adv, nl, cr, home;
`ifdef VGA_TEXT_WRITER_CTRL_EN
  logic        ctrl_pend, ctrl_pend_n;
  logic [31:0] ctrl_data;
  assign CHAR_READY = state == IDLE && init && !clear_pend && !CLEAR && !ctrl_pend && !CTRL_WRITE;
  assign BUSY = state != IDLE || clear_pend || ctrl_pend;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ctrl_pend <= 1'b0;
      ctrl_data <= '0;
    end else begin
      ctrl_pend <= ctrl_pend_n;
      ctrl_data <= CTRL_WRITE ? CTRL_DATA : ctrl_data;
    end
  end
`else
  logic unused_ctrl;
  assign unused_ctrl = ^{CTRL_WRITE, CTRL_DATA};
  assign CHAR_READY = state == IDLE && init && !clear_pend && !CLEAR;
  assign BUSY = state != IDLE || clear_pend;
`endif
  assign done = AVL_M_WRITE && !AVL_M_WAITREQUEST;
  assign accept = CHAR_VALID && CHAR_READY;
  assign is_lf = CHAR_DATA == CH_LF;
  assign is_cr = CHAR_DATA == CH_CR;
  // Pending flags drop at dispatch so a request arriving mid-operation queues exactly one more.
  always_comb begin
    state_n = state;
    addr_n = AVL_M_ADDR;
    write_n = AVL_M_WRITE;
    be_n = AVL_M_BYTE_EN;
    data_n = AVL_M_WRITEDATA;
    clear_pend_n = clear_pend || CLEAR;
`ifdef VGA_TEXT_WRITER_CTRL_EN
    ctrl_pend_n = ctrl_pend || CTRL_WRITE;
`endif
    adv = 1'b0;
    nl = 1'b0;
    cr = 1'b0;
    home = 1'b0;
    case (state)
      IDLE:
        if (clear_pend) begin
          state_n = CLEAR_RUN;
          addr_n = '0;
          write_n = 1'b1;
          be_n = 4'hF;
          data_n = CLEAR_FILL;
          clear_pend_n = CLEAR;
        end
`ifdef VGA_TEXT_WRITER_CTRL_EN
        else if (ctrl_pend) begin
          state_n = CTRL_WR;
          addr_n = 12'(CTRL_ADDR);
          write_n = 1'b1;
          be_n = 4'hF;
          data_n = ctrl_data;
          ctrl_pend_n = CTRL_WRITE;
        end
`endif
        else if (accept) begin
          nl = is_lf;
          cr = is_cr;
          if (!is_lf && !is_cr) begin
            state_n = CHAR_WR;
            addr_n = vram_addr(CURSOR_ROW, CURSOR_COL);
            write_n = 1'b1;
            be_n = 4'b0001 << CURSOR_COL[1:0];
            data_n = {4{CHAR_DATA}};
          end
        end
      CHAR_WR:
        if (done) begin
          state_n = IDLE;
          write_n = 1'b0;
          adv = 1'b1;
        end
      CLEAR_RUN:
        if (done) begin
          if (AVL_M_ADDR == 12'(VRAM_WORDS - 1)) begin
            state_n = IDLE;
            write_n = 1'b0;
            home = 1'b1;
          end else begin
            addr_n = AVL_M_ADDR + 12'd1;
          end
        end
      default:
        if (done) begin
          state_n = IDLE;
          write_n = 1'b0;
        end
    endcase
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      init <= 1'b0;
      clear_pend <= 1'b0;
      AVL_M_ADDR <= '0;
      AVL_M_WRITE <= 1'b0;
      AVL_M_BYTE_EN <= '0;
      AVL_M_WRITEDATA <= '0;
    end else begin
      state <= state_n;
      init <= 1'b1;
      clear_pend <= clear_pend_n;
      AVL_M_ADDR <= addr_n;
      AVL_M_WRITE <= write_n;
      AVL_M_BYTE_EN <= be_n;
      AVL_M_WRITEDATA <= data_n;
    end
  end
  vga_text_cursor u_cursor (
    .clk(CLK),
    .rst(RESET),
    .advance(adv),
    .newline(nl),
    .cr(cr),
    .home(home),
    .col(CURSOR_COL),
    .row(CURSOR_ROW)
  );
endmodule

// File: tb/tb_vga_text_avl_writer.sv
// tb_vga_text_avl_writer: randomized bench comparing vga_text_avl_writer against a queue-based write/cursor model every cycle
module tb_vga_text_avl_writer;
  logic clk = 1'b0;
  logic RESET, CHAR_VALID, CLEAR, CTRL_WRITE;
  logic AVL_M_WAITREQUEST = 1'b0;
  logic [7:0] CHAR_DATA;
  logic [31:0] CTRL_DATA;
  logic CHAR_READY, AVL_M_WRITE, BUSY;
  logic [11:0] AVL_M_ADDR;
  logic [3:0] AVL_M_BYTE_EN;
  logic [31:0] AVL_M_WRITEDATA;
  logic [6:0] CURSOR_COL;
  logic [4:0] CURSOR_ROW;
`ifdef VGA_TEXT_WRITER_CTRL_EN
  localparam bit CTRL_EN = 1'b1;
`else
  localparam bit CTRL_EN = 1'b0;
`endif
  typedef struct {
    logic [11:0] a;
    logic [3:0]  be;
    logic [31:0] d;
    int          k;
  } wr_t;
  wr_t q[$];
  wr_t h;
  int mc, mr, passes, checks, ncomp;
  bit init_m, rnd_wait, wait_force;
  logic exp_ready;
  logic [11:0] last_a;
  logic [3:0] last_be;
  logic [31:0] last_d;

  vga_text_avl_writer dut (
    .CLK(clk), .RESET(RESET), .CHAR_VALID(CHAR_VALID), .CHAR_DATA(CHAR_DATA), .CHAR_READY(CHAR_READY),
    .CLEAR(CLEAR), .CTRL_WRITE(CTRL_WRITE), .CTRL_DATA(CTRL_DATA), .AVL_M_ADDR(AVL_M_ADDR),
    .AVL_M_WRITE(AVL_M_WRITE), .AVL_M_BYTE_EN(AVL_M_BYTE_EN), .AVL_M_WRITEDATA(AVL_M_WRITEDATA),
    .AVL_M_WAITREQUEST(AVL_M_WAITREQUEST), .BUSY(BUSY), .CURSOR_COL(CURSOR_COL), .CURSOR_ROW(CURSOR_ROW)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    AVL_M_WAITREQUEST = rnd_wait ? ($urandom_range(0, 3) == 0) : wait_force;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: queue of writes still owed by the DUT, plus the cursor as it stands after each clock edge.
  always @(negedge clk) begin
    if (RESET) begin
      q.delete();
      mc = 0;
      mr = 0;
      init_m = 1'b0;
      chk("rst_write", AVL_M_WRITE, 0);
      chk("rst_addr", AVL_M_ADDR, 0);
      chk("rst_be", AVL_M_BYTE_EN, 0);
      chk("rst_data", AVL_M_WRITEDATA, 0);
      chk("rst_ready", CHAR_READY, 0);
      chk("rst_col", CURSOR_COL, 0);
      chk("rst_row", CURSOR_ROW, 0);
    end else begin
      exp_ready = init_m && q.size() == 0 && !CLEAR && !(CTRL_EN && CTRL_WRITE);
      chk("ready", CHAR_READY, exp_ready);
      chk("busy", BUSY, q.size() != 0);
      chk("col", CURSOR_COL, mc);
      chk("row", CURSOR_ROW, mr);
      if (AVL_M_WRITE && q.size() == 0) chk("unexpected_write", AVL_M_WRITE, 0);
      else if (AVL_M_WRITE) begin
        chk("addr", AVL_M_ADDR, q[0].a);
        chk("byte_en", AVL_M_BYTE_EN, q[0].be);
        chk("wdata", AVL_M_WRITEDATA, q[0].d);
        if (!AVL_M_WAITREQUEST) begin
          h = q.pop_front();
          ncomp++;
          last_a = AVL_M_ADDR;
          last_be = AVL_M_BYTE_EN;
          last_d = AVL_M_WRITEDATA;
          if (h.k == 0) begin
            mc++;
            if (mc == 80) begin
              mc = 0;
              mr = (mr + 1) % 30;
            end
          end
          if (h.k == 1) begin
            mc = 0;
            mr = 0;
          end
        end
      end
      if (CHAR_VALID && exp_ready) begin
        if (CHAR_DATA == 8'h0A) begin
          mc = 0;
          mr = (mr + 1) % 30;
        end else if (CHAR_DATA == 8'h0D) mc = 0;
        else q.push_back('{12'(mr * 20 + mc / 4), 4'(1 << (mc % 4)), {4{CHAR_DATA}}, 0});
      end
      if (CLEAR)
        for (int i = 0; i < 600; i++) q.push_back('{12'(i), 4'hF, 32'h2020_2020, (i == 599) ? 1 : 2});
`ifdef VGA_TEXT_WRITER_CTRL_EN
      if (CTRL_WRITE) q.push_back('{12'd600, 4'hF, CTRL_DATA, 2});
`endif
      init_m = 1'b1;
    end
  end

  task automatic send_char(input logic [7:0] c);
    int n = 0;
    @(posedge clk);
    #1;
    CHAR_VALID = 1'b1;
    CHAR_DATA = c;
    do begin
      @(negedge clk);
      n++;
    end while (!CHAR_READY && n < 5000);
    chk("send_timeout", CHAR_READY, 1);
    @(posedge clk);
    #1;
    CHAR_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (BUSY && n < 5000);
    chk("idle_timeout", BUSY, 0);
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #1;
    CLEAR = 1'b1;
    @(posedge clk);
    #1;
    CLEAR = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, w, c0;
    logic [7:0] c;
    RESET = 1'b1;
    CHAR_VALID = 1'b0;
    CHAR_DATA = '0;
    CLEAR = 1'b0;
    CTRL_WRITE = 1'b0;
    CTRL_DATA = '0;
    rnd_wait = 1'b0;
    wait_force = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    RESET = 1'b0;
    @(negedge clk);
    chk("init_ready_low", CHAR_READY, 0);
    @(negedge clk);
    chk("init_ready_high", CHAR_READY, 1);

    send_char(8'h41);
    @(negedge clk);
    chk("a_write", AVL_M_WRITE, 1);
    chk("a_addr", AVL_M_ADDR, 12'd0);
    chk("a_be", AVL_M_BYTE_EN, 4'b0001);
    chk("a_data", AVL_M_WRITEDATA, 32'h4141_4141);
    @(negedge clk);
    chk("a_col", CURSOR_COL, 1);
    chk("a_row", CURSOR_ROW, 0);
    chk("a_ready_again", CHAR_READY, 1);

    send_char(8'h0D);
    send_char(8'h0A);
    @(negedge clk);
    chk("crlf_col", CURSOR_COL, 0);
    chk("crlf_row", CURSOR_ROW, 1);
    wait_force = 1'b1;
    send_char(8'hC8);
    n = 0;
    do begin
      @(negedge clk);
      if (AVL_M_WRITE) begin
        n++;
        chk("c8_addr", AVL_M_ADDR, 12'd20);
        chk("c8_be", AVL_M_BYTE_EN, 4'b0001);
        chk("c8_data", AVL_M_WRITEDATA, 32'hC8C8_C8C8);
        if (n == 3) wait_force = 1'b0;
      end
    end while (AVL_M_WRITE && n < 20);
    chk("c8_write_cycles", n, 4);
    chk("c8_col", CURSOR_COL, 1);
    chk("c8_row", CURSOR_ROW, 1);

    @(posedge clk);
    #1;
    CLEAR = 1'b1;
    CHAR_VALID = 1'b1;
    CHAR_DATA = 8'h5A;
    @(negedge clk);
    chk("clr_blocks_char", CHAR_READY, 0);
    @(posedge clk);
    #1;
    CLEAR = 1'b0;
    n = 0;
    w = 0;
    do begin
      @(negedge clk);
      n++;
      if (AVL_M_WRITE) w++;
    end while (BUSY && n < 2000);
    chk("clr_cycles", n, 602);
    chk("clr_writes", w, 600);
    chk("clr_col", CURSOR_COL, 0);
    chk("clr_row", CURSOR_ROW, 0);
    chk("clr_then_ready", CHAR_READY, 1);
    @(posedge clk);
    #1;
    CHAR_VALID = 1'b0;
    @(negedge clk);
    chk("z_addr", AVL_M_ADDR, 12'd0);
    chk("z_data", AVL_M_WRITEDATA, 32'h5A5A_5A5A);
    wait_idle();

    c0 = ncomp;
    pulse_clear();
    repeat (100) @(posedge clk);
    pulse_clear();
    wait_idle();
    chk("double_clear_writes", ncomp - c0, 1200);

    rnd_wait = 1'b1;
    c0 = ncomp;
    for (int i = 0; i < 2400; i++) begin
      c = 8'($urandom_range(0, 255));
      if (c[6:0] == 7'h0A || c[6:0] == 7'h0D) c = c ^ 8'h01;
      if ($urandom_range(0, 3) == 0) @(posedge clk);
      send_char(c);
    end
    wait_idle();
    rnd_wait = 1'b0;
    chk("fill_writes", ncomp - c0, 2400);
    chk("fill_last_addr", last_a, 12'd599);
    chk("fill_last_be", last_be, 4'b1000);
    chk("fill_col", CURSOR_COL, 0);
    chk("fill_row", CURSOR_ROW, 0);

    c0 = ncomp;
    @(posedge clk);
    #1;
    CTRL_WRITE = 1'b1;
    CTRL_DATA = 32'h01FE_0000;
    @(negedge clk);
`ifdef VGA_TEXT_WRITER_CTRL_EN
    chk("ctrl_blocks_char", CHAR_READY, 0);
`else
    chk("ctrl_ignored_ready", CHAR_READY, 1);
`endif
    @(posedge clk);
    #1;
    CTRL_WRITE = 1'b0;
    repeat (10) @(negedge clk);
    wait_idle();
`ifdef VGA_TEXT_WRITER_CTRL_EN
    chk("ctrl_writes", ncomp - c0, 1);
    chk("ctrl_addr", last_a, 12'd600);
    chk("ctrl_be", last_be, 4'hF);
    chk("ctrl_data", last_d, 32'h01FE_0000);
`else
    chk("ctrl_no_writes", ncomp - c0, 0);
`endif

    send_char(8'h51);
    wait_idle();
    chk("q_col", CURSOR_COL, 1);
    pulse_clear();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(AVL_M_WRITE && AVL_M_ADDR == 12'd36) && n < 200);
    chk("reach_addr36", AVL_M_ADDR, 12'd36);
    wait_force = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stall_addr37", AVL_M_ADDR, 12'd37);
    chk("stall_write", AVL_M_WRITE, 1);
    @(posedge clk);
    #3;
    RESET = 1'b1;
    #1;
    chk("async_write_drop", AVL_M_WRITE, 0);
    chk("async_col", CURSOR_COL, 0);
    chk("async_row", CURSOR_ROW, 0);
    wait_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    RESET = 1'b0;
    @(negedge clk);
    chk("post_rst_ready_low", CHAR_READY, 0);
    @(negedge clk);
    chk("post_rst_ready_high", CHAR_READY, 1);
    chk("post_rst_busy", BUSY, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
